// File: rtl/pc_sequencer.sv
// Program-counter sequencer with trap vectoring, redirect and a circular return-address stack.
// Next-PC priority: trap, then (under pc_en) redirect, ret-pop, sequential step.
module pc_sequencer #(
    parameter int unsigned WIDTH     = 8,
    parameter logic [31:0] STEP      = 32'd1,
    parameter logic [31:0] RESET_VEC = 32'd0,
    parameter logic [31:0] TRAP_VEC  = 32'hF0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_en,
    input  logic             trap,
    input  logic             redirect,
    input  logic [WIDTH-1:0] target,
    input  logic             call,
    input  logic             ret,
    input  logic             clear_err,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_udf
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [WIDTH-1:0] STEP_W  = STEP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_W = RESET_VEC[WIDTH-1:0];
    localparam logic [WIDTH-1:0] TRAP_W  = TRAP_VEC[WIDTH-1:0];
    localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic [WIDTH-1:0] seq_pc;
    logic [PW-1:0]    top_idx;
    logic             push, pop;

    // ptr_q addresses the next free slot; when full it is also the oldest entry,
    // so a push-when-full overwrites it naturally.
    assign seq_pc  = pc_q + STEP_W;
    assign top_idx = ptr_q - PW'(1);

    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q & ~clear_err;
        udf_d = udf_q & ~clear_err;
        push  = 1'b0;
        pop   = 1'b0;
        for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            ras_d[i] = ras_q[i];
        end

        if (trap) begin
            pc_d = TRAP_W;
        end else if (pc_en) begin
            if (redirect) begin
                pc_d = target;
                push = call;
            end else if (ret && cnt_q != '0) begin
                pc_d = ras_q[top_idx];
                pop  = 1'b1;
            end else begin
                pc_d = seq_pc;
                if (ret) begin
                    udf_d = 1'b1;
                end
            end
        end

        if (push) begin
            ras_d[ptr_q] = seq_pc;
            ptr_d = ptr_q + PW'(1);
            if (cnt_q == FULL_CNT) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_W;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

    assign pc_out    = pc_q;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL_CNT);
    assign ras_top   = ras_empty ? '0 : ras_q[top_idx];
    assign ras_ovf   = ovf_q;
    assign ras_udf   = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer at default parameters: per-cycle vector table
// plus hand-written sequences for counting wrap and asynchronous reset.
module tb_pc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pc_en, trap, redirect, call, ret, clear_err;
    logic [7:0] target;
    logic [7:0] pc_out, ras_top;
    logic       ras_empty, ras_full, ras_ovf, ras_udf;

    int total;
    int bad;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .trap(trap),
        .redirect(redirect), .target(target), .call(call), .ret(ret),
        .clear_err(clear_err), .pc_out(pc_out), .ras_top(ras_top),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
        .ras_udf(ras_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, trp, rdr, cal, rt, clr;
        logic [7:0] tgt;
        logic [7:0] pc, top;
        logic       empty, full, ovf, udf;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic trp, input logic rdr, input logic cal,
                         input logic rt, input logic clr, input logic [7:0] tgt);
        pc_en = en; trap = trp; redirect = rdr; call = cal; ret = rt; clear_err = clr; target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //            en trp rdr cal rt clr tgt     pc     top   emp ful ovf udf
        tbl[0]  = '{1, 0, 1, 0, 0, 0, 8'h10, 8'h10, 8'h00, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 1, 0, 0, 8'h40, 8'h40, 8'h11, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 1, 0, 8'h00, 8'h11, 8'h00, 1, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 0, 0, 8'h0A, 8'h0A, 8'h00, 1, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, 1, 0, 0, 8'h20, 8'h20, 8'h0B, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 1, 0, 0, 0, 8'h0A, 8'h0A, 8'h0B, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 1, 1, 0, 0, 8'h21, 8'h21, 8'h0B, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 1, 0, 0, 0, 8'h0A, 8'h0A, 8'h0B, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 1, 1, 0, 0, 8'h22, 8'h22, 8'h0B, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 1, 0, 0, 0, 8'h0A, 8'h0A, 8'h0B, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 1, 1, 0, 0, 8'h23, 8'h23, 8'h0B, 0, 1, 0, 0};
        tbl[11] = '{1, 0, 1, 0, 0, 0, 8'h0A, 8'h0A, 8'h0B, 0, 1, 0, 0};
        tbl[12] = '{1, 0, 1, 1, 0, 0, 8'h24, 8'h24, 8'h0B, 0, 1, 1, 0};
        tbl[13] = '{1, 0, 0, 0, 1, 0, 8'h00, 8'h0B, 8'h0B, 0, 0, 1, 0};
        tbl[14] = '{1, 0, 0, 0, 1, 0, 8'h00, 8'h0B, 8'h0B, 0, 0, 1, 0};
        tbl[15] = '{1, 0, 0, 0, 1, 0, 8'h00, 8'h0B, 8'h0B, 0, 0, 1, 0};
        tbl[16] = '{1, 0, 0, 0, 1, 0, 8'h00, 8'h0B, 8'h00, 1, 0, 1, 0};
        tbl[17] = '{1, 0, 0, 0, 1, 0, 8'h00, 8'h0C, 8'h00, 1, 0, 1, 1};
        tbl[18] = '{1, 0, 0, 0, 1, 1, 8'h00, 8'h0D, 8'h00, 1, 0, 0, 1};
        tbl[19] = '{1, 0, 0, 0, 0, 1, 8'h00, 8'h0E, 8'h00, 1, 0, 0, 0};
        tbl[20] = '{1, 0, 1, 1, 0, 0, 8'h50, 8'h50, 8'h0F, 0, 0, 0, 0};
        tbl[21] = '{1, 0, 1, 0, 1, 0, 8'h80, 8'h80, 8'h0F, 0, 0, 0, 0};
        tbl[22] = '{1, 0, 1, 0, 0, 0, 8'h33, 8'h33, 8'h0F, 0, 0, 0, 0};
        tbl[23] = '{0, 1, 0, 0, 1, 0, 8'h00, 8'hF0, 8'h0F, 0, 0, 0, 0};
        tbl[24] = '{0, 0, 0, 0, 1, 0, 8'h00, 8'hF0, 8'h0F, 0, 0, 0, 0};
        tbl[25] = '{1, 1, 1, 1, 0, 0, 8'h66, 8'hF0, 8'h0F, 0, 0, 0, 0};
        tbl[26] = '{1, 0, 0, 0, 1, 0, 8'h00, 8'h0F, 8'h00, 1, 0, 0, 0};
        tbl[27] = '{1, 0, 1, 0, 0, 0, 8'hFF, 8'hFF, 8'h00, 1, 0, 0, 0};
        tbl[28] = '{1, 0, 1, 1, 0, 0, 8'h05, 8'h05, 8'h00, 0, 0, 0, 0};
        tbl[29] = '{1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        step();
        step();
        chk("rst_pc", pc_out, 8'h00);
        chk("rst_top", ras_top, 8'h00);
        chk("rst_empty", ras_empty, 1'b1);
        chk("rst_full", ras_full, 1'b0);
        chk("rst_ovf", ras_ovf, 1'b0);
        chk("rst_udf", ras_udf, 1'b0);

        // Free-running count with wrap 255 -> 0
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 300; i++) begin
            step();
            chk("count_pc", pc_out, 32'(i % 256));
        end

        for (int v = 0; v < NV; v++) begin
            drive(tbl[v].en, tbl[v].trp, tbl[v].rdr, tbl[v].cal, tbl[v].rt, tbl[v].clr, tbl[v].tgt);
            step();
            chk($sformatf("v%0d_pc", v), pc_out, tbl[v].pc);
            chk($sformatf("v%0d_top", v), ras_top, tbl[v].top);
            chk($sformatf("v%0d_empty", v), ras_empty, tbl[v].empty);
            chk($sformatf("v%0d_full", v), ras_full, tbl[v].full);
            chk($sformatf("v%0d_ovf", v), ras_ovf, tbl[v].ovf);
            chk($sformatf("v%0d_udf", v), ras_udf, tbl[v].udf);
        end

        // Build depth 3 at pc 0x57, then pulse reset between edges
        drive(1, 0, 1, 1, 0, 0, 8'h30); step();
        drive(1, 0, 1, 1, 0, 0, 8'h31); step();
        drive(1, 0, 1, 1, 0, 0, 8'h57); step();
        chk("pre_rst_pc", pc_out, 8'h57);
        chk("pre_rst_top", ras_top, 8'h32);
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc_out, 8'h00);
        chk("async_rst_empty", ras_empty, 1'b1);
        chk("async_rst_top", ras_top, 8'h00);
        step();
        chk("held_rst_pc", pc_out, 8'h00);
        rst_n = 1'b1;
        step();
        chk("first_edge_pc", pc_out, 8'h01);
        chk("first_edge_empty", ras_empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: PC and address width in bits (range 4..32).
REQ-002 Parameter STEP, default 1: sequential increment added to the PC.
REQ-003 Parameter RESET_VEC, default 0: PC value loaded at reset.
REQ-004 Parameter TRAP_VEC, default 8'hF0 (truncated/zero-extended to WIDTH): PC value loaded on trap.
REQ-005 Parameter RAS_DEPTH, default 4: return-address-stack entries (power of two, >= 2).
REQ-006 clk  input  1: single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-008 pc_en  input  1: advance enable; when 0, PC and stack hold unless trap=1.
REQ-009 trap  input  1: force PC to TRAP_VEC; highest priority; honoured regardless of pc_en.
REQ-010 redirect  input  1: load PC from target (branch/jump taken).
REQ-011 target  input  WIDTH: redirect destination.
REQ-012 call  input  1: with redirect, push return address pc_out+STEP.
REQ-013 ret  input  1: pop the stack and load the popped value into the PC.
REQ-014 clear_err  input  1: clear sticky error flags.
REQ-015 pc_out  output  WIDTH: current PC, registered.
REQ-016 ras_top  output  WIDTH: top-of-stack entry; 0 when empty.
REQ-017 ras_empty / ras_full  output  1 each: stack occupancy == 0 / == RAS_DEPTH.
REQ-018 ras_ovf / ras_udf  output  1 each: sticky overflow / underflow flags.

Function
REQ-019 Next PC is selected by priority in one cycle: trap -> TRAP_VEC; else if pc_en: redirect -> target; ret with stack non-empty -> popped entry; otherwise pc_out+STEP.
REQ-020 Sequential and return-address arithmetic is modulo 2^WIDTH (wrap-around, no flag).
REQ-021 Latency: a control input sampled at edge N is reflected on pc_out, ras_top and the flags after edge N; there is no combinational input-to-output path.
REQ-022 A push occurs only when pc_en=1, trap=0, redirect=1 and call=1; call without redirect is ignored.
REQ-023 A pop occurs only when pc_en=1, trap=0, redirect=0 and ret=1; ret together with redirect is ignored.
REQ-024 Push when full: the oldest entry is discarded (circular overwrite), occupancy stays RAS_DEPTH, the new entry becomes top, and ras_ovf is set.
REQ-025 Pop when empty: PC takes pc_out+STEP, the stack is unchanged, and ras_udf is set.
REQ-026 trap never modifies the stack; call/ret asserted in a trap cycle are ignored.
REQ-027 pc_en=0 with trap=0: PC, stack and flags hold; only clear_err acts.
REQ-028 clear_err clears ras_ovf and ras_udf; if a set event occurs in the same cycle, set wins.
REQ-029 Stack storage: RAS_DEPTH x WIDTH register array, log2(RAS_DEPTH)-bit top pointer, and a log2(RAS_DEPTH)+1-bit count.

Reset
REQ-030 While rst_n=0: pc_out=RESET_VEC, count=0, pointer=0, all entries=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_udf=0, ras_top=0.
REQ-031 Reset asserted mid-operation takes effect immediately and asynchronously, discarding any pending update; deassertion is synchronised externally.
REQ-032 The first update after deassertion occurs on the first rising edge with rst_n=1.

Verification (defaults WIDTH=8, STEP=1, RAS_DEPTH=4)
REQ-033 Reset, then pc_en=1 for 300 cycles -> pc_out counts 0,1,...,255,0,...; wraps at 255->0.
REQ-034 With pc_out=0x10: redirect=1, call=1, target=0x40 -> pc_out=0x40, ras_top=0x11; next cycle ret=1 -> pc_out=0x11, ras_empty=1.
REQ-035 Five calls to targets 0x20..0x24, each issued from pc_out=0x0A -> ras_full=1, ras_ovf=1, ras_top=0x0B; four rets then drain the stack; a fifth ret -> ras_udf=1, pc_out=previous+1.
REQ-036 trap=1 with pc_en=0 and ret=1 at pc_out=0x33 -> pc_out=0xF0, stack occupancy unchanged.
REQ-037 Same cycle redirect=1, ret=1, target=0x80 -> pc_out=0x80, no pop; clear_err=1 coincident with an underflow -> ras_udf stays 1.
REQ-038 rst_n pulsed low between clock edges at pc_out=0x57 with stack depth 3 -> pc_out=0x00 and ras_empty=1 before the next edge.
